// File: rtl/adc_serial_reader_pkg.sv
// Shared types and derived timing for the serial ADC front end.
package adc_serial_reader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONVERT   = 3'd1,
    WAIT_CONV = 3'd2,
    SHIFT     = 3'd3,
    DONE      = 3'd4,
    HOLD      = 3'd5
  } state_e;

  // Shortest start-to-start interval the frame sequence can sustain.
  function automatic int unsigned frame_min(input int unsigned convst_cycles,
                                            input int unsigned conv_cycles,
                                            input int unsigned sclk_half,
                                            input int unsigned data_width);
    return convst_cycles + conv_cycles + 32'd2 * sclk_half * data_width + 32'd1;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: idles high, toggles every SCLK_HALF cycles while run is high,
// and flags the cycle before each low-to-high transition plus the last one of the word.
module adc_sclk_gen #(
  parameter int SCLK_HALF  = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic sample_en,
  output logic bits_done
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  logic [HW-1:0] half_cnt_r;
  logic [BW-1:0] bit_cnt_r;
  logic          sclk_r;
  logic          toggle_s;

  // Edge qualifiers are decoded from the current count so the sample lands on the rising edge itself.
  always_comb begin
    toggle_s  = run && (half_cnt_r == HALF_LAST);
    sample_en = toggle_s && !sclk_r;
    bits_done = sample_en && (bit_cnt_r == BIT_LAST);
  end

  // Half-period counter, clock level and rising-edge count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_r <= {HW{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      sclk_r     <= 1'b1;
    end else if (!run) begin
      half_cnt_r <= {HW{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      sclk_r     <= 1'b1;
    end else if (toggle_s) begin
      half_cnt_r <= {HW{1'b0}};
      sclk_r     <= ~sclk_r;
      if (!sclk_r) begin
        bit_cnt_r <= bit_cnt_r + {{(BW-1){1'b0}}, 1'b1};
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end else begin
      half_cnt_r <= half_cnt_r + {{(HW-1){1'b0}}, 1'b1};
    end
  end

  assign sclk = sclk_r;

endmodule

// File: rtl/adc_serial_reader.sv
// Periodic serial ADC reader: convst pulse, conversion wait, MSB-first readout,
// then a parallel word with a one-cycle data_ready strobe.
module adc_serial_reader
  import adc_serial_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int SCLK_HALF     = 2,
  parameter int CONVST_CYCLES = 4,
  parameter int CONV_CYCLES   = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [15:0]           period,
  input  logic                  adc_sdo,
  output logic                  adc_convst,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_ready,
  output logic                  period_short
);

  localparam logic [15:0] FRAME_MIN_W =
    16'(frame_min(CONVST_CYCLES, CONV_CYCLES, SCLK_HALF, DATA_WIDTH));
  localparam logic [15:0] CONVST_LAST = 16'(CONVST_CYCLES - 1);
  localparam logic [15:0] CONV_LAST   = 16'(CONV_CYCLES - 1);

  state_e                state_r;
  logic [15:0]           phase_r;
  logic [15:0]           per_cnt_r;
  logic [15:0]           period_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  convst_r;
  logic                  cs_n_r;
  logic                  data_ready_r;
  logic                  period_short_r;
  logic                  run_s;
  logic                  sample_en_s;
  logic                  bits_done_s;
  logic [15:0]           period_load_s;

  // A zero period loads zero rather than wrapping.
  always_comb begin
    run_s         = (state_r == SHIFT);
    period_load_s = (period == 16'd0) ? 16'd0 : (period - 16'd1);
  end

  adc_sclk_gen #(
    .SCLK_HALF  (SCLK_HALF),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run_s),
    .sclk      (adc_sclk),
    .sample_en (sample_en_s),
    .bits_done (bits_done_s)
  );

  // Frame sequencer with registered ADC controls, result word and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      phase_r        <= 16'd0;
      per_cnt_r      <= 16'd0;
      period_r       <= 16'd0;
      shift_r        <= {DATA_WIDTH{1'b0}};
      data_r         <= {DATA_WIDTH{1'b0}};
      convst_r       <= 1'b0;
      cs_n_r         <= 1'b1;
      data_ready_r   <= 1'b0;
      period_short_r <= 1'b0;
    end else begin
      data_ready_r <= 1'b0;
      if ((state_r != IDLE) && (per_cnt_r != 16'd0)) begin
        per_cnt_r <= per_cnt_r - 16'd1;
      end
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r   <= CONVERT;
            convst_r  <= 1'b1;
            phase_r   <= 16'd0;
            per_cnt_r <= period_load_s;
            period_r  <= period;
          end
        end
        CONVERT: begin
          if (phase_r == CONVST_LAST) begin
            state_r  <= WAIT_CONV;
            convst_r <= 1'b0;
            phase_r  <= 16'd0;
          end else begin
            phase_r <= phase_r + 16'd1;
          end
        end
        WAIT_CONV: begin
          if (phase_r == CONV_LAST) begin
            state_r <= SHIFT;
            cs_n_r  <= 1'b0;
            phase_r <= 16'd0;
          end else begin
            phase_r <= phase_r + 16'd1;
          end
        end
        SHIFT: begin
          if (sample_en_s) begin
            shift_r <= {shift_r[DATA_WIDTH-2:0], adc_sdo};
          end
          if (bits_done_s) begin
            state_r <= DONE;
            cs_n_r  <= 1'b1;
          end
        end
        DONE: begin
          data_r       <= shift_r;
          data_ready_r <= 1'b1;
          state_r      <= HOLD;
        end
        HOLD: begin
          // A start here with a short period was held back to the frame length.
          if (per_cnt_r == 16'd0) begin
            if (enable) begin
              state_r   <= CONVERT;
              convst_r  <= 1'b1;
              phase_r   <= 16'd0;
              per_cnt_r <= period_load_s;
              period_r  <= period;
              if (period_r < FRAME_MIN_W) begin
                period_short_r <= 1'b1;
              end
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          convst_r <= 1'b0;
          cs_n_r   <= 1'b1;
        end
      endcase
    end
  end

  assign adc_convst   = convst_r;
  assign adc_cs_n     = cs_n_r;
  assign data         = data_r;
  assign data_ready   = data_ready_r;
  assign period_short = period_short_r;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Scoreboard bench: an ADC model serves words, a protocol monitor checks frame timing,
// and the data_ready monitor compares results and latency against queued expectations.
module tb_adc_serial_reader;
  import adc_serial_reader_pkg::*;

  localparam int FRAME_MIN = 4 + 40 + 2 * 2 * 16 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd200;
  logic        adc_sdo = 1'b0;
  logic        adc_convst, adc_cs_n, adc_sclk, data_ready, period_short;
  logic [15:0] data;

  adc_serial_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .period       (period),
    .adc_sdo      (adc_sdo),
    .adc_convst   (adc_convst),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .data         (data),
    .data_ready   (data_ready),
    .period_short (period_short)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ADC model: word chosen at chip-select fall, MSB presented on the first sclk fall.
  logic [15:0] words_q[$];
  logic [15:0] sb_q[$];
  int          start_q[$];
  logic [15:0] cur_word = 16'd0;
  int          bit_i = -1;

  always @(negedge adc_cs_n) begin
    if (rst_n) begin
      if (words_q.size() > 0) cur_word = words_q.pop_front();
      else cur_word = 16'($urandom_range(0, 65535));
      sb_q.push_back(cur_word);
      bit_i   = 15;
      adc_sdo = 1'b0;
    end
  end

  always @(negedge adc_sclk) begin
    if (!adc_cs_n && bit_i >= 0) begin
      adc_sdo = cur_word[bit_i];
      bit_i--;
    end
  end

  // Protocol and result monitor.
  logic prev_convst = 1'b0, prev_cs_n = 1'b1, prev_sclk = 1'b1, prev_ready = 1'b0;
  int   n_starts = 0, n_ready = 0;
  int   last_start = 0, exp_int = 0, conv_fall = 0;
  int   convst_len = 0, cs_len = 0, rises = 0;
  bit   have_last = 1'b0, seen_dis = 1'b0;
  int   acc_cnt = 0, acc_sum = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      start_q.delete();
      have_last  = 1'b0;
      convst_len = 0;
      cs_len     = 0;
      rises      = 0;
    end else begin
      if (!enable) seen_dis = 1'b1;
      if (adc_convst && !prev_convst) begin
        n_starts++;
        start_q.push_back(cyc);
        if (have_last && !seen_dis) check("start_interval", cyc - last_start, exp_int);
        last_start = cyc;
        exp_int    = (int'(period) < FRAME_MIN) ? FRAME_MIN + 1 : int'(period);
        have_last  = 1'b1;
        seen_dis   = 1'b0;
        convst_len = 0;
      end
      if (adc_convst) convst_len++;
      if (!adc_convst && prev_convst) begin
        check("convst_width", convst_len, 4);
        conv_fall = cyc;
      end
      if (!adc_cs_n && prev_cs_n) check("conv_gap", cyc - conv_fall, 40);
      if (!adc_cs_n) cs_len++;
      if (!prev_cs_n && adc_sclk && !prev_sclk) rises++;
      if (adc_cs_n && !prev_cs_n) begin
        check("cs_low_len", cs_len, 64);
        check("sclk_rises", rises, 16);
        cs_len = 0;
        rises  = 0;
      end
      if (data_ready) begin
        n_ready++;
        check("ready_single_cycle", prev_ready, 0);
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) check("data", data, sb_q.pop_front());
        if (start_q.size() > 0) check("latency", cyc - start_q.pop_front(), FRAME_MIN);
        acc_cnt++;
        acc_sum += int'(data);
      end
    end
    prev_convst = adc_convst;
    prev_cs_n   = adc_cs_n;
    prev_sclk   = adc_sclk;
    prev_ready  = data_ready;
  end

  task automatic wait_ready(input int n);
    int target = n_ready + n;
    int k = 0;
    while (n_ready < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", n_ready >= target, 1);
  endtask

  task automatic wait_start();
    int target = n_starts + 1;
    int k = 0;
    while (n_starts < target && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("start_wait", n_starts >= target, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (dut.state_r != IDLE && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", dut.state_r == IDLE, 1);
  endtask

  task automatic wait_cs_low();
    int k = 0;
    while (adc_cs_n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("cs_low_wait", adc_cs_n, 0);
  endtask

  int starts_snap;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_convst", adc_convst, 0);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 1);
    check("rst_data", data, 0);
    check("rst_ready", data_ready, 0);
    check("rst_short", period_short, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal period with a fixed first word then random ones.
    words_q.push_back(16'hA5C3);
    period = 16'd200;
    enable = 1'b1;
    wait_ready(3);
    check("nominal_short", period_short, 0);
    enable = 1'b0;
    wait_idle();

    // Short period: frames back to back, sticky flag from the second start.
    period = 16'd50;
    enable = 1'b1;
    wait_start();
    check("short_first_start", period_short, 0);
    wait_start();
    check("short_second_start", period_short, 1);
    wait_ready(3);
    check("short_sticky", period_short, 1);
    enable = 1'b0;
    wait_idle();

    // Extreme words.
    words_q.push_back(16'hFFFF);
    words_q.push_back(16'h0001);
    period = 16'd130;
    enable = 1'b1;
    wait_ready(2);
    enable = 1'b0;
    wait_idle();

    // Enable dropped during readout: frame still completes, then stays idle.
    words_q.push_back(16'h1234);
    period = 16'd200;
    enable = 1'b1;
    wait_cs_low();
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_ready(1);
    starts_snap = n_starts;
    repeat (300) @(negedge clk);
    check("no_restart", n_starts, starts_snap);
    check("idle_after_drop", dut.state_r == IDLE, 1);
    check("convst_low_after_drop", adc_convst, 0);
    check("data_held", data, 16'h1234);

    // Asynchronous reset in the middle of readout.
    enable = 1'b1;
    wait_cs_low();
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_cs_n", adc_cs_n, 1);
    check("async_sclk", adc_sclk, 1);
    check("async_data", data, 0);
    check("async_ready", data_ready, 0);
    check("async_short", period_short, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(1);
    enable = 1'b0;
    wait_idle();

    // Accumulator-style consumption of five frames.
    acc_cnt = 0;
    acc_sum = 0;
    for (int i = 1; i <= 5; i++) words_q.push_back(16'(100 * i));
    period = 16'd200;
    enable = 1'b1;
    wait_ready(5);
    enable = 1'b0;
    check("acc_count", acc_cnt, 5);
    check("acc_sum", acc_sum, 1500);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
